// File: rtl/ex_pkg.sv
// Shared types for the execute-stage operand/decode pipe.
// Opselect/operation encodings and the buffered entry layout.
package ex_pkg;

    localparam int EX_WIDTH = 32;
    localparam int EX_IMM_W = 16;
    localparam int EX_SHW   = $clog2(EX_WIDTH);

    typedef enum logic [2:0] {
        SHIFT_REG   = 3'b000,
        ARITH_LOGIC = 3'b001,
        MEM_WRITE   = 3'b100,
        MEM_READ    = 3'b101
    } opsel_e;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        XOR = 3'd4,
        NOT = 3'd5,
        MOV = 3'd6,
        LHG = 3'd7
    } op_e;

    typedef struct packed {
        logic [2:0]          operation;
        logic [2:0]          opselect;
        logic [EX_WIDTH-1:0] aluin1;
        logic [EX_WIDTH-1:0] aluin2;
        logic [EX_WIDTH-1:0] mem_data;
        logic [EX_SHW-1:0]   shift_number;
        logic                mem_wr_en;
        logic                enable_arith;
        logic                enable_shift;
    } ex_entry_t;

endpackage

// File: rtl/ex_decode_comb.sv
// Combinational decode of control/operands into one ex_entry_t.
// No state; the enclosing pipe registers the result.
module ex_decode_comb
    import ex_pkg::*;
#(
    parameter int WIDTH = EX_WIDTH,
    parameter int IMM_W = EX_IMM_W,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [IMM_W-1:0] imm_i,
    input  logic [6:0]       control_i,
    output ex_entry_t        entry_o
);

    logic [WIDTH-1:0] sext;
    logic [WIDTH-1:0] upper;
    logic             imm_sel;

    assign sext    = {{(WIDTH-IMM_W){imm_i[IMM_W-1]}}, imm_i};
    assign upper   = {imm_i, {(WIDTH-IMM_W){1'b0}}};
    assign imm_sel = control_i[3];

    always_comb begin
        entry_o           = '0;
        entry_o.operation = control_i[6:4];
        entry_o.opselect  = control_i[2:0];
        entry_o.aluin1    = src1_i;
        entry_o.aluin2    = src2_i;
        entry_o.mem_data  = src2_i;
        unique case (control_i[2:0])
            SHIFT_REG: begin
                entry_o.enable_shift = 1'b1;
                entry_o.shift_number = imm_sel ? imm_i[6+:SHW]
                                               : src2_i[SHW-1:0];
            end
            ARITH_LOGIC: begin
                entry_o.enable_arith = 1'b1;
                // LHG loads the immediate into the upper half
                if (imm_sel)
                    entry_o.aluin2 = (control_i[6:4] == LHG) ? upper : sext;
            end
            MEM_READ: begin
                entry_o.enable_arith = 1'b1;
                entry_o.aluin2       = sext;
            end
            MEM_WRITE: begin
                entry_o.mem_wr_en = imm_sel;
                entry_o.aluin2    = sext;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ex_decode_pipe.sv
// Execute-stage decode with a 2-entry skid buffer on the output.
// Define EX_BYPASS_EN to add writeback forwarding onto src1/src2.
module ex_decode_pipe
    import ex_pkg::*;
#(
    parameter int WIDTH = EX_WIDTH,
    parameter int IMM_W = EX_IMM_W,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [IMM_W-1:0] imm,
    input  logic [6:0]       control_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       operation_out,
    output logic [2:0]       opselect_out,
    output logic [WIDTH-1:0] aluin1,
    output logic [WIDTH-1:0] aluin2,
    output logic [SHW-1:0]   shift_number,
    output logic [WIDTH-1:0] mem_data_write_out,
    output logic             mem_data_wr_en,
    output logic             enable_arith,
    output logic             enable_shift
`ifdef EX_BYPASS_EN
    ,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    input  logic [4:0]       src1_rs,
    input  logic [4:0]       src2_rs
`endif
);

    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;

`ifdef EX_BYPASS_EN
    assign op1 = (wb_valid && wb_rd != 5'd0 && wb_rd == src1_rs)
               ? wb_data : src1;
    assign op2 = (wb_valid && wb_rd != 5'd0 && wb_rd == src2_rs)
               ? wb_data : src2;
`else
    assign op1 = src1;
    assign op2 = src2;
`endif

    ex_entry_t dec;

    ex_decode_comb #(
        .WIDTH (WIDTH),
        .IMM_W (IMM_W),
        .SHW   (SHW)
    ) u_dec (
        .src1_i    (op1),
        .src2_i    (op2),
        .imm_i     (imm),
        .control_i (control_in),
        .entry_o   (dec)
    );

    ex_entry_t m_q, m_d, s_q, s_d;
    logic      m_valid_q, m_valid_d;
    logic      s_valid_q, s_valid_d;
    logic      accept, pop;

    assign in_ready = !s_valid_q;
    assign accept   = in_valid && in_ready;
    assign pop      = m_valid_q && out_ready;

    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (pop) begin
            // accept cannot coincide with a valid skid entry
            if (s_valid_q) begin
                m_d       = s_q;
                s_valid_d = 1'b0;
            end else if (accept) begin
                m_d = dec;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!m_valid_q) begin
                m_d       = dec;
                m_valid_d = 1'b1;
            end else begin
                s_d       = dec;
                s_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            m_q       <= '0;
            s_q       <= '0;
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            m_q       <= m_d;
            s_q       <= s_d;
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
        end
    end

    assign out_valid          = m_valid_q;
    assign operation_out      = m_q.operation;
    assign opselect_out       = m_q.opselect;
    assign aluin1             = m_q.aluin1;
    assign aluin2             = m_q.aluin2;
    assign shift_number       = m_q.shift_number;
    assign mem_data_write_out = m_q.mem_data;
    assign mem_data_wr_en     = m_q.mem_wr_en && m_valid_q;
    assign enable_arith       = m_q.enable_arith && m_valid_q;
    assign enable_shift       = m_q.enable_shift && m_valid_q;

endmodule

// File: tb/tb_ex_decode_pipe.sv
// Bench for ex_decode_pipe: directed cases plus random traffic
// checked against a queue-based reference of the decode pipe.
module tb_ex_decode_pipe;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] src1 = '0, src2 = '0;
    logic [15:0] imm = '0;
    logic [6:0]  control_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  operation_out, opselect_out;
    logic [31:0] aluin1, aluin2, mem_data_write_out;
    logic [4:0]  shift_number;
    logic        mem_data_wr_en, enable_arith, enable_shift;
`ifdef EX_BYPASS_EN
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0, src1_rs = '0, src2_rs = '0;
    logic [31:0] wb_data = '0;
`endif

    always #5 CLOCK = ~CLOCK;

    ex_decode_pipe dut (
        .CLOCK              (CLOCK),
        .RESET              (RESET),
        .flush              (flush),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .src1               (src1),
        .src2               (src2),
        .imm                (imm),
        .control_in         (control_in),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .operation_out      (operation_out),
        .opselect_out       (opselect_out),
        .aluin1             (aluin1),
        .aluin2             (aluin2),
        .shift_number       (shift_number),
        .mem_data_write_out (mem_data_write_out),
        .mem_data_wr_en     (mem_data_wr_en),
        .enable_arith       (enable_arith),
        .enable_shift       (enable_shift)
`ifdef EX_BYPASS_EN
        ,
        .wb_valid           (wb_valid),
        .wb_rd              (wb_rd),
        .wb_data            (wb_data),
        .src1_rs            (src1_rs),
        .src2_rs            (src2_rs)
`endif
    );

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  sel;
        logic [31:0] a1, a2, md;
        logic [4:0]  sh;
        logic        wr, ar, sf;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] s1, s2,
                                     input logic [15:0] im,
                                     input logic [6:0] c);
        exp_t e;
        logic signed [31:0] sx;
        sx    = $signed(im);
        e.op  = c[6:4];
        e.sel = c[2:0];
        e.a1  = s1;
        e.a2  = s2;
        e.md  = s2;
        e.sh  = '0;
        e.wr  = 0;
        e.ar  = 0;
        e.sf  = 0;
        if (e.sel == 3'd0) begin
            e.sf = 1;
            e.sh = c[3] ? 5'((im >> 6) % 32) : 5'(s2 % 32);
        end else if (e.sel == 3'd1) begin
            e.ar = 1;
            if (c[3]) e.a2 = (e.op == 3'd7) ? (32'(im) << 16) : sx;
        end else if (e.sel == 3'd5) begin
            e.ar = 1;
            e.a2 = sx;
        end else if (e.sel == 3'd4) begin
            e.wr = c[3];
            e.a2 = sx;
        end
        return e;
    endfunction

    function automatic exp_t cur_entry();
        logic [31:0] s1, s2;
        s1 = src1;
        s2 = src2;
`ifdef EX_BYPASS_EN
        if (wb_valid && wb_rd != 0 && wb_rd == src1_rs) s1 = wb_data;
        if (wb_valid && wb_rd != 0 && wb_rd == src2_rs) s2 = wb_data;
`endif
        return ref_dec(s1, s2, imm, control_in);
    endfunction

    task automatic model_update();
        bit acc, pp;
        acc = in_valid && (q.size() < 2);
        pp  = (q.size() > 0) && out_ready;
        if (RESET || flush) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(cur_entry());
        end
    endtask

    task automatic check_model();
        exp_t e;
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (q.size() > 0) begin
            e = q[0];
            chk("operation", operation_out, e.op);
            chk("opselect", opselect_out, e.sel);
            chk("aluin1", aluin1, e.a1);
            chk("aluin2", aluin2, e.a2);
            chk("mem_data", mem_data_write_out, e.md);
            chk("shift", shift_number, e.sh);
            chk("wr_en", mem_data_wr_en, e.wr);
            chk("en_arith", enable_arith, e.ar);
            chk("en_shift", enable_shift, e.sf);
        end else begin
            chk("idle_en", {mem_data_wr_en, enable_arith, enable_shift}, 0);
        end
    endtask

    task automatic cyc();
        @(posedge CLOCK);
        model_update();
        @(negedge CLOCK);
        check_model();
    endtask

    initial begin
        repeat (2) @(negedge CLOCK);
        RESET = 1'b0;
        cyc();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_aluin1", aluin1, 0);
        chk("rst_aluin2", aluin2, 0);
        chk("rst_md", mem_data_write_out, 0);
        chk("rst_ctrl", {operation_out, opselect_out, shift_number}, 0);
        chk("rst_en", {mem_data_wr_en, enable_arith, enable_shift}, 0);

        in_valid = 1; out_ready = 1;
        control_in = 7'b000_1_001; imm = 16'hFFF0; src1 = 5;
        cyc();
        chk("arith_valid", out_valid, 1);
        chk("arith_a1", aluin1, 32'd5);
        chk("arith_sext", aluin2, 32'hFFFF_FFF0);
        chk("arith_en", enable_arith, 1);

        control_in = 7'b111_1_001; imm = 16'h1234;
        cyc();
        chk("lhg_a2", aluin2, 32'h1234_0000);

        control_in = 7'b000_1_000; imm = 16'h0240;
        cyc();
        chk("shift_imm", shift_number, 5'd9);
        chk("shift_en", enable_shift, 1);
        control_in = 7'b000_0_000; src2 = 32'h23;
        cyc();
        chk("shift_reg", shift_number, 5'd3);
        in_valid = 0;
        cyc();

        control_in = 7'b000_0_001; out_ready = 0; in_valid = 1;
        src1 = 1; cyc();
        src1 = 2; cyc();
        chk("skid_full", in_ready, 0);
        src1 = 3; cyc();
        chk("stall_a", aluin1, 1);
        cyc();
        chk("stall_a2", aluin1, 1);
        out_ready = 1;
        cyc();
        chk("order_b", aluin1, 2);
        cyc();
        chk("order_c", aluin1, 3);
        in_valid = 0;
        cyc();
        chk("drained", out_valid, 0);

        out_ready = 0; in_valid = 1;
        cyc(); cyc();
        flush = 1;
        cyc();
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        flush = 0; in_valid = 0;
        cyc();
        chk("flush_empty", out_valid, 0);

`ifdef EX_BYPASS_EN
        out_ready = 1; in_valid = 1; src1 = 11;
        wb_valid = 1; wb_rd = 3; wb_data = 77; src1_rs = 3;
        cyc();
        chk("byp_hit", aluin1, 77);
        wb_rd = 0;
        cyc();
        chk("byp_x0", aluin1, 11);
        in_valid = 0; wb_valid = 0;
        cyc();
`endif

        for (int i = 0; i < 600; i++) begin
            RESET      = ($urandom_range(0, 63) == 0);
            flush      = ($urandom_range(0, 15) == 0);
            in_valid   = ($urandom_range(0, 1) == 1);
            out_ready  = ($urandom_range(0, 9) < 6);
            src1       = $urandom;
            src2       = $urandom;
            imm        = 16'($urandom);
            control_in = 7'($urandom);
`ifdef EX_BYPASS_EN
            wb_valid   = ($urandom_range(0, 1) == 1);
            wb_rd      = 5'($urandom_range(0, 3));
            wb_data    = $urandom;
            src1_rs    = 5'($urandom_range(0, 3));
            src2_rs    = 5'($urandom_range(0, 3));
`endif
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
